spi_target: RTL and testbench
=============================

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of flip-flops in each synchronizer on the spi_clk, spi_mosi and spi_cs inputs (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: when 0 the device behaves as deselected.
REQ-005 SHALL have ports cpol and cpha, inputs, 1 bit each: SPI clock polarity and clock phase.
REQ-006 SHALL have port spi_clk, input, 1 bit: SCK driven by the bus controller.
REQ-007 SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-008 SHALL have port spi_cs, input, 1 bit: chip select, active low.
REQ-009 SHALL have port spi_miso, output, 1 bit: serial data out, MSB first.
REQ-010 SHALL have port spi_miso_en, output, 1 bit: enable for the MISO pad driver.
REQ-011 SHALL have ports tx_data, input, 8 bits, and tx_valid, input, 1 bit: byte offered for transmission.
REQ-012 SHALL have port tx_ready, output, 1 bit: high when the one-entry transmit holding register is empty.
REQ-013 SHALL have ports rx_data, output, 8 bits, and rx_valid, output, 1 bit: received byte and its one-cycle strobe.
REQ-014 SHALL have port busy, output, 1 bit: high while selected.
REQ-015 SHALL have ports tx_underrun and frame_error, outputs, 1 bit each: sticky status flags.
REQ-016 SHALL have port status_clear, input, 1 bit: a pulse that clears both sticky flags.

Function
REQ-017 SHALL synchronize spi_clk, spi_mosi and spi_cs through SYNC_STAGES flops and detect SCK edges from the last two synchronized samples. spi_clk is at most clk/8.
REQ-018 SHALL be selected when the synchronized spi_cs is 0 and enable is 1.
REQ-019 SHALL capture cpol and cpha on the select edge and hold them for the whole frame.
REQ-020 SHALL treat the leading edge as rising when cpol=0 and falling when cpol=1. The sample edge is the leading edge if cpha=0 and the trailing edge if cpha=1; the shift edge is the other one.
REQ-021 SHALL use two states: IDLE and SHIFT.
  - IDLE->SHIFT on select.
  - SHIFT->IDLE on deselect.
  - A 3-bit bit counter is cleared on entry to SHIFT.
REQ-022 On each sample edge, SHALL shift the synchronized MOSI into the receive shift register LSB and increment the bit counter modulo 8.
REQ-023 On the sample edge that wraps the bit counter to 0, SHALL present the completed byte on rx_data and pulse rx_valid for exactly one clk cycle. rx_data holds until the next completed byte.
REQ-024 SHALL accept transmit data when tx_valid and tx_ready are both 1 on a clk edge. tx_ready falls on the following cycle.
REQ-025 SHALL load the transmit shift register as follows:
  - cpha=0: on the select edge, and on each shift edge where the bit counter is 0.
  - cpha=1: on each shift edge where the bit counter is 0.
  - Every other shift edge shifts left by one.
REQ-026 On a load with the holding register full, SHALL transfer the holding register and set tx_ready. On a load with it empty, SHALL load 0xFF and set tx_underrun.
REQ-027 SHALL drive spi_miso from the transmit shift register MSB and set spi_miso_en to 1 only while selected. While deselected, spi_miso=0.
REQ-028 On deselect with a nonzero bit counter, SHALL discard the partial byte, not pulse rx_valid, set frame_error, and keep the holding register contents.
REQ-029 SHALL give priority to set over clear when status_clear coincides with a flag-setting event.
REQ-030 SHALL ignore SCK edges while in IDLE.
REQ-031 SHALL handle a tx_valid acceptance and a load in the same cycle by transmitting the old holding contents, with the new byte written into the holding register.

Reset
REQ-032 SHALL, when rst is asserted, immediately force:
  - State IDLE, bit counter 0.
  - rx_data=0x00, rx_valid=0.
  - spi_miso=0, spi_miso_en=0, busy=0.
  - Both status flags 0.
  - Holding register empty, tx_ready=1.
  - Synchronizers set to spi_cs=1 and spi_clk=0.
REQ-033 SHALL discard any byte in progress when reset is asserted mid-frame, without raising rx_valid.

Structure
REQ-034 SHALL place the state encoding and the 0xFF underrun fill constant in a shared SPI package.
REQ-035 SHALL implement the synchronizer as one sub-module, spi_input_sync, instantiated three times.

Verification
REQ-036 Mode 0, SCK period 16 clk, controller sends 0xA3, tx preloaded 0x1F -> rx_data=0xA3 with one rx_valid pulse, controller receives 0x1F.
REQ-037 Mode 3, two-byte burst 0x1F then 0x83, tx 0x55 then 0xC5 written during the first byte -> two rx_valid pulses with 0x1F then 0x83, controller receives 0x55 then 0xC5, tx_underrun=0.
REQ-038 Mode 0, no tx_valid given, controller sends 0x9B -> controller receives 0xFF, tx_underrun=1; then status_clear -> tx_underrun=0.
REQ-039 Deselect after 5 bits, then a full byte 0x3C -> no rx_valid for the partial byte, frame_error=1, next rx_data=0x3C.
REQ-040 rst asserted after 4 bits of a frame -> all outputs at reset values within the same cycle; after release, new frame 0x7E is received correctly.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared SPI target definitions: FSM state encoding and the transmit underrun fill byte.
package spi_target_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] UNDERRUN_FILL = 8'hFF;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, with a selectable reset level.
module spi_input_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= {STAGES{RST_VAL}};
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI target (all four modes) oversampled by the system clock, with a one-entry transmit
// holding register, byte receive strobe and sticky underrun / frame-error flags.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  output logic        spi_miso,
  output logic        spi_miso_en,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        tx_underrun,
  output logic        frame_error,
  input  logic        status_clear
);

  logic       sclk_s, mosi_s, cs_s, sclk_prev;
  spi_state_e state, state_next;
  logic       sel, sel_edge, desel_edge, in_frame;
  logic       cpol_q, cpha_q;
  logic       rise, fall, lead, trail, sample_edge, shift_edge;
  logic       load, accept;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift, hold_data;
  logic       hold_full;

  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_s));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));
  spi_input_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s));

  assign sel = ~cs_s & enable;

  always_comb begin
    state_next = state;
    sel_edge   = 1'b0;
    desel_edge = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          state_next = SHIFT;
          sel_edge   = 1'b1;
        end
      end
      SHIFT: begin
        if (!sel) begin
          state_next = IDLE;
          desel_edge = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // SCK edges only matter inside a frame, using the mode latched at select time.
  assign in_frame    = (state == SHIFT) && sel;
  assign rise        = sclk_s & ~sclk_prev;
  assign fall        = ~sclk_s & sclk_prev;
  assign lead        = cpol_q ? fall : rise;
  assign trail       = cpol_q ? rise : fall;
  assign sample_edge = in_frame & (cpha_q ? trail : lead);
  assign shift_edge  = in_frame & (cpha_q ? lead : trail);
  assign load        = (sel_edge & ~cpha) | (shift_edge & (bit_cnt == 3'd0));
  assign accept      = tx_valid & ~hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sclk_prev <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_shift  <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_underrun <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state     <= state_next;
      sclk_prev <= sclk_s;
      rx_valid  <= 1'b0;

      if (sel_edge) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        bit_cnt <= 3'd0;
      end

      if (sample_edge) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift, mosi_s};
          rx_valid <= 1'b1;
        end
      end

      if (load) begin
        tx_shift <= hold_full ? hold_data : UNDERRUN_FILL;
      end else if (shift_edge) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // Acceptance only happens when empty, so it never collides with a transfer out.
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end

      if (load && !hold_full) begin
        tx_underrun <= 1'b1;
      end else if (status_clear) begin
        tx_underrun <= 1'b0;
      end

      if (desel_edge && (bit_cnt != 3'd0)) begin
        frame_error <= 1'b1;
      end else if (status_clear) begin
        frame_error <= 1'b0;
      end
    end
  end

  assign busy        = (state == SHIFT);
  assign spi_miso_en = busy;
  assign spi_miso    = busy & tx_shift[7];
  assign tx_ready    = ~hold_full;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboarded bench for spi_target: SPI controller tasks drive frames, a monitor checks rx bytes.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst, enable, cpol, cpha, sclk, mosi, cs;
  logic       miso, miso_en, tx_valid, tx_ready, rx_valid, busy;
  logic       tx_underrun, frame_error, status_clear;
  logic [7:0] tx_data, rx_data, got;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  spi_target #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cpol(cpol), .cpha(cpha),
    .spi_clk(sclk), .spi_mosi(mosi), .spi_cs(cs),
    .spi_miso(miso), .spi_miso_en(miso_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_error(frame_error),
    .status_clear(status_clear));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got 0x%02h, expected no byte", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data: got 0x%02h, expected 0x%02h", rx_data, e);
        end
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    status_clear = 1'b1;
    wait_clk(1);
    status_clear = 1'b0;
    wait_clk(1);
  endtask

  task automatic cs_begin(input logic cp, input logic ph);
    cpol = cp;
    cpha = ph;
    sclk = cp;
    wait_clk(8);
    cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_end();
    wait_clk(8);
    cs = 1'b1;
    wait_clk(8);
  endtask

  // Controller side: drives MOSI and samples MISO on the edges its mode dictates.
  task automatic spi_bits(input logic cp, input logic ph, input logic [7:0] dout,
                          input int nbits, output logic [7:0] din);
    din = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!ph) begin
        mosi = dout[i];
        wait_clk(8);
        din[i] = miso;
        sclk = ~cp;
        wait_clk(8);
        sclk = cp;
      end else begin
        wait_clk(8);
        sclk = ~cp;
        mosi = dout[i];
        wait_clk(8);
        din[i] = miso;
        sclk = cp;
      end
    end
  endtask

  initial begin
    logic [7:0] got2;
    rst = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0;
    sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; status_clear = 1'b0;
    wait_clk(4);
    check8("reset_rx_data", rx_data, 8'h00);
    check1("reset_busy", busy, 1'b0);
    check1("reset_miso_en", miso_en, 1'b0);
    check1("reset_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    wait_clk(4);

    // Mode 0, single byte
    write_tx(8'h1F);
    check1("tx_ready_after_write", tx_ready, 1'b0);
    exp_q.push_back(8'hA3);
    cs_begin(1'b0, 1'b0);
    check1("busy_selected", busy, 1'b1);
    check1("miso_en_selected", miso_en, 1'b1);
    spi_bits(1'b0, 1'b0, 8'hA3, 8, got);
    cs_end();
    check8("m0_miso_byte", got, 8'h1F);
    check1("miso_deselected", miso, 1'b0);
    pulse_clear();

    // Mode 3, two-byte burst; second tx byte written while the first is on the wire
    write_tx(8'h55);
    exp_q.push_back(8'h1F);
    exp_q.push_back(8'h83);
    cs_begin(1'b1, 1'b1);
    fork
      begin
        spi_bits(1'b1, 1'b1, 8'h1F, 8, got);
        spi_bits(1'b1, 1'b1, 8'h83, 8, got2);
      end
      begin
        int n;
        n = 0;
        while (!tx_ready && n < 200) begin
          wait_clk(1);
          n++;
        end
        check1("m3_tx_ready_rise", tx_ready, 1'b1);
        write_tx(8'hC5);
      end
    join
    cs_end();
    check8("m3_miso_byte0", got, 8'h55);
    check8("m3_miso_byte1", got2, 8'hC5);
    check1("m3_no_underrun", tx_underrun, 1'b0);
    sclk = 1'b0;
    wait_clk(8);

    // Underrun
    check1("pre_underrun_clear", tx_underrun, 1'b0);
    exp_q.push_back(8'h9B);
    cs_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 8'h9B, 8, got);
    cs_end();
    check8("underrun_fill", got, 8'hFF);
    check1("underrun_set", tx_underrun, 1'b1);
    pulse_clear();
    check1("underrun_cleared", tx_underrun, 1'b0);

    // Partial frame then full byte
    cs_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 8'hF0, 5, got);
    cs_end();
    check1("frame_error_set", frame_error, 1'b1);
    check1("busy_after_partial", busy, 1'b0);
    exp_q.push_back(8'h3C);
    cs_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 8'h3C, 8, got);
    cs_end();
    check8("rx_data_after_partial", rx_data, 8'h3C);

    // Reset in the middle of a frame
    cs_begin(1'b0, 1'b0);
    write_tx(8'h5A);
    spi_bits(1'b0, 1'b0, 8'h7E, 4, got);
    #2 rst = 1'b1;
    #1;
    check8("midrst_rx_data", rx_data, 8'h00);
    check1("midrst_rx_valid", rx_valid, 1'b0);
    check1("midrst_miso", miso, 1'b0);
    check1("midrst_miso_en", miso_en, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_underrun", tx_underrun, 1'b0);
    check1("midrst_frame_error", frame_error, 1'b0);
    check1("midrst_tx_ready", tx_ready, 1'b1);
    cs = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(8);
    write_tx(8'hA5);
    exp_q.push_back(8'h7E);
    cs_begin(1'b0, 1'b0);
    spi_bits(1'b0, 1'b0, 8'h7E, 8, got);
    cs_end();
    check8("post_rst_miso_byte", got, 8'hA5);
    check8("post_rst_rx_data", rx_data, 8'h7E);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_clk(1);
    check8("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
